qr_givens_sched: RTL and testbench
==================================

// Module: qr_givens_sched
// PURPOSE
//  Sequencer for QR decomposition of an 8x4 signed matrix by Givens rotations
//  on one shared CORDIC processing element. Accepts 8 rows over the 52-bit
//  row bus, schedules every vectoring and rotation op onto the PE over a
//  req/ack handshake, writes results back, then streams the 8 rows of R out.
//  Sits between the host row interface and the CORDIC PE inside QR_CORDIC.
// PARAMETERS
//  DW    13  element width, two's complement
//  ROWS  8   matrix rows
//  COLS  4   matrix columns (row bus = COLS*DW = 52)
//  ITER  12  CORDIC micro-rotations (width of direction vector)
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous reset, active-high
//  valid        in   1        input row beat valid
//  in           in   52       row; element k at [k*DW +: DW]
//  out_valid    out  1        output row beat valid
//  out          out  52       R row, same packing as in
//  busy         out  1        high from first accepted beat to last out beat
//  cordic_req   out  1        PE op request
//  cordic_mode  out  1        0 = vectoring, 1 = rotation
//  cordic_x     out  DW       PE x operand
//  cordic_y     out  DW       PE y operand
//  cordic_dir_o out  ITER     directions for rotation ops (held from last vectoring)
//  cordic_ack   in   1        PE result valid, one-cycle pulse
//  cordic_xr    in   DW       PE x result (gain-compensated, saturated by PE)
//  cordic_yr    in   DW       PE y result
//  cordic_dir_i in   ITER     directions produced by a vectoring op
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, row buffer 0, req drops at once.
//  States: IDLE -> LOAD -> VEC_REQ -> VEC_WAIT -> ROT_REQ -> ROT_WAIT -> NEXT -> OUT -> IDLE.
//  IDLE/LOAD: each valid beat writes row r (r=0..7 in arrival order); after row 7
//   go VEC_REQ. valid ignored in all other states (extra beats dropped).
//  Schedule: for col j=0..3, for row i=7 downto j+1: vectoring on
//   (x=A[i-1][j], y=A[i][j]); then for k=j+1..3 rotation on (A[i-1][k], A[i][k]).
//   Totals: 22 vectoring + 38 rotation ops per matrix; col 3 has no rotations.
//  Handshake: req rises in *_REQ, operands/mode/dir stable while req high;
//   on ack in *_WAIT latch results, req low next cycle; >=1 idle cycle between
//   ops. ack while req low is ignored. No timeout; PE latency unbounded.
//  Write-back: vectoring -> A[i-1][j]<=xr, A[i][j]<=0 (forced, not yr),
//   dir latched to cordic_dir_o. Rotation -> A[i-1][k]<=xr, A[i][k]<=yr.
//  NEXT: advance k/i/j; after (j=3,i=4) vectoring go OUT.
//  OUT: 8 consecutive cycles out_valid=1, rows 0..7 in index order; out=0 when
//   out_valid=0. busy falls with last beat; IDLE accepts new matrix next cycle.
//  Widths: no arithmetic in this block beyond counters; values stored as-is.
//  rst mid-operation (any state): abort, discard buffer, req/out_valid/busy 0.
// STRUCTURE
//  qr_cordic_pkg: DW/ROWS/COLS/ITER localparams, state enum, MODE_VEC/MODE_ROT.
//  Sub-module qr_row_buf: ROWSxCOLS register file, 2 element read ports,
//   2 element write ports, row-wide write (load) and row-wide read (out).
//  Top holds FSM, j/i/k/row counters, handshake and dir register.
// TESTING (bench uses a behavioural ideal-CORDIC model with configurable latency)
//  All-zero matrix -> exactly 22 vec + 38 rot req pulses, 8 zero out rows.
//  A[0][0]=3, A[1][0]=4, rest 0 -> out row0 col0=5, all sub-diagonal elems 0.
//  Random matrix, PE latency 1 vs 7 vs random 1..20 -> identical out rows.
//  valid held 9 cycles -> 9th beat ignored, result equals 8-beat run.
//  rst pulse during ROT_WAIT -> req/busy/out_valid 0 same cycle; fresh load OK.
//  Spurious ack in IDLE and between ops -> no write-back, results unchanged.

Source files
------------

// File: rtl/qr_cordic_pkg.sv
// rtl/qr_cordic_pkg.sv - shared sizes, op modes and FSM states for the Givens QR sequencer
package qr_cordic_pkg;
  localparam int DW   = 13;
  localparam int ROWS = 8;
  localparam int COLS = 4;
  localparam int ITER = 12;
  localparam int RW   = COLS * DW;

  localparam logic MODE_VEC = 1'b0;
  localparam logic MODE_ROT = 1'b1;

  typedef enum logic [2:0] {
    IDLE, LOAD, VEC_REQ, VEC_WAIT, ROT_REQ, ROT_WAIT, NEXT, OUT
  } state_t;
endpackage

// File: rtl/qr_row_buf.sv
// rtl/qr_row_buf.sv - ROWSxCOLS element register file with row-wide load/read and two element ports
module qr_row_buf
  import qr_cordic_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_en,
  input  logic [2:0]    ld_row,
  input  logic [RW-1:0] ld_data,
  input  logic [2:0]    rd_row,
  output logic [RW-1:0] rd_data,
  input  logic [2:0]    e0_row,
  input  logic [1:0]    e0_col,
  output logic [DW-1:0] e0_rdata,
  input  logic          e0_we,
  input  logic [DW-1:0] e0_wdata,
  input  logic [2:0]    e1_row,
  input  logic [1:0]    e1_col,
  output logic [DW-1:0] e1_rdata,
  input  logic          e1_we,
  input  logic [DW-1:0] e1_wdata
);
  logic [DW-1:0] mem [ROWS][COLS];

  // Each element port reads and writes the same cell, so a PE result lands where its operand came from.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          mem[r][c] <= '0;
    end else begin
      if (ld_en)
        for (int c = 0; c < COLS; c++)
          mem[ld_row][c] <= ld_data[c*DW +: DW];
      if (e0_we) mem[e0_row][e0_col] <= e0_wdata;
      if (e1_we) mem[e1_row][e1_col] <= e1_wdata;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < COLS; c++)
      rd_data[c*DW +: DW] = mem[rd_row][c];
  end

  assign e0_rdata = mem[e0_row][e0_col];
  assign e1_rdata = mem[e1_row][e1_col];
endmodule

// File: rtl/qr_givens_sched.sv
// rtl/qr_givens_sched.sv - loads an 8x4 matrix, schedules Givens ops on a shared CORDIC PE, streams R out
module qr_givens_sched
  import qr_cordic_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [RW-1:0]   in,
  output logic            out_valid,
  output logic [RW-1:0]   out,
  output logic            busy,
  output logic            cordic_req,
  output logic            cordic_mode,
  output logic [DW-1:0]   cordic_x,
  output logic [DW-1:0]   cordic_y,
  output logic [ITER-1:0] cordic_dir_o,
  input  logic            cordic_ack,
  input  logic [DW-1:0]   cordic_xr,
  input  logic [DW-1:0]   cordic_yr,
  input  logic [ITER-1:0] cordic_dir_i
);
  state_t state, state_nx;

  logic [2:0]    row_cnt;
  logic [2:0]    i_cnt;
  logic [1:0]    j_cnt;
  logic [1:0]    k_cnt;
  logic [2:0]    up_row;
  logic [1:0]    col;
  logic [DW-1:0] a_data;
  logic [DW-1:0] b_data;
  logic [RW-1:0] rd_data;
  logic          ld_en;
  logic          wr_en;
  logic [DW-1:0] low_wdata;
  logic          rot_more;
  logic          last_vec;
  logic          col_done;

  assign up_row    = i_cnt - 3'd1;
  assign cordic_mode = (state == ROT_REQ) || (state == ROT_WAIT);
  assign col       = cordic_mode ? k_cnt : j_cnt;
  assign ld_en     = valid && ((state == IDLE) || (state == LOAD));
  // Acks only count while a request is outstanding, which is exactly the WAIT states.
  assign wr_en     = cordic_ack && ((state == VEC_WAIT) || (state == ROT_WAIT));
  assign low_wdata = (state == ROT_WAIT) ? cordic_yr : '0;
  assign rot_more  = (j_cnt != 2'd3) && (k_cnt != 2'd3);
  assign col_done  = (i_cnt == ({1'b0, j_cnt} + 3'd1));
  assign last_vec  = (j_cnt == 2'd3) && col_done;

  qr_row_buf u_buf (
    .clk      (clk),
    .rst      (rst),
    .ld_en    (ld_en),
    .ld_row   (row_cnt),
    .ld_data  (in),
    .rd_row   (row_cnt),
    .rd_data  (rd_data),
    .e0_row   (up_row),
    .e0_col   (col),
    .e0_rdata (a_data),
    .e0_we    (wr_en),
    .e0_wdata (cordic_xr),
    .e1_row   (i_cnt),
    .e1_col   (col),
    .e1_rdata (b_data),
    .e1_we    (wr_en),
    .e1_wdata (low_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (valid) state_nx = LOAD;
      LOAD:     if (valid && row_cnt == 3'd7) state_nx = VEC_REQ;
      VEC_REQ:  state_nx = VEC_WAIT;
      VEC_WAIT: if (cordic_ack) state_nx = (j_cnt == 2'd3) ? NEXT : ROT_REQ;
      ROT_REQ:  state_nx = ROT_WAIT;
      ROT_WAIT: if (cordic_ack) state_nx = NEXT;
      NEXT:     state_nx = rot_more ? ROT_REQ : (last_vec ? OUT : VEC_REQ);
      OUT:      if (row_cnt == 3'd7) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // row_cnt serves both load and readout; it wraps to 0 after row 7 in each phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt <= '0;
      i_cnt   <= '0;
      j_cnt   <= '0;
      k_cnt   <= '0;
    end else begin
      if (ld_en || state == OUT) row_cnt <= row_cnt + 3'd1;
      if (state == LOAD && valid && row_cnt == 3'd7) begin
        j_cnt <= '0;
        i_cnt <= 3'd7;
      end
      if (state == VEC_WAIT && cordic_ack) k_cnt <= j_cnt + 2'd1;
      if (state == NEXT) begin
        if (rot_more) begin
          k_cnt <= k_cnt + 2'd1;
        end else if (col_done) begin
          j_cnt <= j_cnt + 2'd1;
          i_cnt <= 3'd7;
        end else begin
          i_cnt <= i_cnt - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cordic_req   <= 1'b0;
      cordic_dir_o <= '0;
    end else begin
      if (state == VEC_REQ || state == ROT_REQ) cordic_req <= 1'b1;
      else if (wr_en)                           cordic_req <= 1'b0;
      if (state == VEC_WAIT && cordic_ack) cordic_dir_o <= cordic_dir_i;
    end
  end

  assign cordic_x  = cordic_req ? a_data : '0;
  assign cordic_y  = cordic_req ? b_data : '0;
  assign out_valid = (state == OUT);
  assign out       = out_valid ? rd_data : '0;
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_qr_givens_sched.sv
// tb/tb_qr_givens_sched.sv - scoreboard bench with an ideal-CORDIC PE model and a floating-point Givens reference
module tb_qr_givens_sched;
  import qr_cordic_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            valid = 1'b0;
  logic [RW-1:0]   in = '0;
  logic            out_valid;
  logic [RW-1:0]   out;
  logic            busy;
  logic            cordic_req;
  logic            cordic_mode;
  logic [DW-1:0]   cordic_x;
  logic [DW-1:0]   cordic_y;
  logic [ITER-1:0] cordic_dir_o;
  logic            cordic_ack = 1'b0;
  logic [DW-1:0]   cordic_xr = '0;
  logic [DW-1:0]   cordic_yr = '0;
  logic [ITER-1:0] cordic_dir_i = '0;

  qr_givens_sched dut (
    .clk(clk), .rst(rst), .valid(valid), .in(in),
    .out_valid(out_valid), .out(out), .busy(busy),
    .cordic_req(cordic_req), .cordic_mode(cordic_mode),
    .cordic_x(cordic_x), .cordic_y(cordic_y), .cordic_dir_o(cordic_dir_o),
    .cordic_ack(cordic_ack), .cordic_xr(cordic_xr), .cordic_yr(cordic_yr),
    .cordic_dir_i(cordic_dir_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] cap[ROWS];
  logic [RW-1:0] mon_exp;
  int cap_idx = 0;
  int mat[ROWS][COLS];
  int refm[ROWS][COLS];
  int pe_lat = 1;
  bit pe_rand = 0;
  bit pe_spur = 0;
  int vec_cnt = 0;
  int rot_cnt = 0;
  real ang_map[int];
  logic [ROWS*RW-1:0] snap1, snap2, snap3;

  function automatic int sat(input int v);
    if (v > 4095) return 4095;
    if (v < -4096) return -4096;
    return v;
  endfunction
  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
  endfunction
  function automatic int vec_mag(input int x, input int y);
    return sat(rnd($sqrt(real'(x*x + y*y))));
  endfunction
  function automatic real vec_ang(input int x, input int y);
    return $atan2(real'(y), real'(x));
  endfunction
  function automatic int rot_x(input int x, input int y, input real a);
    return sat(rnd($cos(a) * x + $sin(a) * y));
  endfunction
  function automatic int rot_y(input int x, input int y, input real a);
    return sat(rnd(-$sin(a) * x + $cos(a) * y));
  endfunction
  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h required=%h", nm, got, want);
    end
  endtask

  // Reference: textbook column-by-column Givens elimination on the bench's own integer matrix.
  task automatic ref_push();
    real a;
    int x, y;
    logic [RW-1:0] row;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        refm[r][c] = mat[r][c];
    for (int j = 0; j < COLS; j++)
      for (int i = ROWS - 1; i > j; i--) begin
        x = refm[i-1][j];
        y = refm[i][j];
        a = vec_ang(x, y);
        refm[i-1][j] = vec_mag(x, y);
        refm[i][j] = 0;
        for (int k = j + 1; k < COLS; k++) begin
          x = refm[i-1][k];
          y = refm[i][k];
          refm[i-1][k] = rot_x(x, y, a);
          refm[i][k] = rot_y(x, y, a);
        end
      end
    for (int r = 0; r < ROWS; r++) begin
      row = '0;
      for (int c = 0; c < COLS; c++)
        row[c*DW +: DW] = DW'(refm[r][c]);
      exp_q.push_back(row);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic load(input int beats, input bit push);
    wait_idle();
    if (push) ref_push();
    for (int r = 0; r < beats; r++) begin
      valid = 1'b1;
      for (int c = 0; c < COLS; c++)
        if (r < ROWS) in[c*DW +: DW] = DW'(mat[r][c]);
        else          in[c*DW +: DW] = DW'($urandom);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    in = '0;
  endtask

  task automatic rand_mat();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mat[r][c] = int'($urandom_range(0, 600)) - 300;
  endtask

  task automatic run_check(input string nm);
    wait_idle();
    chk(nm, exp_q.size(), 0);
  endtask

  // Ideal CORDIC PE: directions are opaque tags that index the angle of the vectoring op that made them.
  initial begin
    int wait_n;
    int rx, ry, rd, px, py;
    bit pend;
    real a;
    pend = 0;
    wait_n = 0;
    rx = 0; ry = 0; rd = 0;
    forever begin
      @(posedge clk); #2;
      cordic_ack = 1'b0;
      if (rst) begin
        pend = 0;
      end else if (!pend && cordic_req) begin
        px = sx(cordic_x);
        py = sx(cordic_y);
        if (cordic_mode == MODE_VEC) begin
          vec_cnt++;
          a = vec_ang(px, py);
          rx = vec_mag(px, py);
          ry = int'($urandom_range(1, 4095));
          rd = int'($urandom_range(0, 4095));
          ang_map[rd] = a;
        end else begin
          rot_cnt++;
          a = ang_map.exists(int'(cordic_dir_o)) ? ang_map[int'(cordic_dir_o)] : 0.0;
          rx = rot_x(px, py, a);
          ry = rot_y(px, py, a);
          rd = int'($urandom_range(0, 4095));
        end
        wait_n = pe_rand ? int'($urandom_range(1, 20)) : pe_lat;
        pend = 1;
      end else if (!pend && pe_spur && $urandom_range(0, 3) == 0) begin
        cordic_ack   = 1'b1;
        cordic_xr    = DW'($urandom);
        cordic_yr    = DW'($urandom);
        cordic_dir_i = ITER'($urandom);
      end
      if (pend && !rst) begin
        wait_n--;
        if (wait_n <= 0) begin
          cordic_ack   = 1'b1;
          cordic_xr    = DW'(rx);
          cordic_yr    = DW'(ry);
          cordic_dir_i = ITER'(rd);
          pend = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected got=%h required=none", out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out !== mon_exp) begin
          bad++;
          $display("FAIL out_row%0d got=%h required=%h", cap_idx, out, mon_exp);
        end
      end
      cap[cap_idx] = out;
      cap_idx = (cap_idx + 1) % ROWS;
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_req", cordic_req, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_x", cordic_x, 0);
    chk("rst_dir", cordic_dir_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // All-zero matrix: exact op counts
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mat[r][c] = 0;
    vec_cnt = 0;
    rot_cnt = 0;
    load(8, 1);
    run_check("zero_drain");
    chk("zero_vec_ops", vec_cnt, 22);
    chk("zero_rot_ops", rot_cnt, 38);

    // 3-4-5 matrix with spurious acks around every op
    pe_spur = 1;
    mat[0][0] = 3;
    mat[1][0] = 4;
    load(8, 1);
    run_check("345_drain");
    chk("345_r0c0", cap[0][DW-1:0], 5);
    for (int r = 1; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (c < r) chk($sformatf("345_sub_r%0dc%0d", r, c), cap[r][c*DW +: DW], 0);
    pe_spur = 0;

    // Same random matrix under three PE latency profiles
    rand_mat();
    pe_lat = 1; pe_rand = 0;
    load(8, 1);
    run_check("lat1_drain");
    for (int r = 0; r < ROWS; r++) snap1[r*RW +: RW] = cap[r];
    pe_lat = 7;
    load(8, 1);
    run_check("lat7_drain");
    for (int r = 0; r < ROWS; r++) snap2[r*RW +: RW] = cap[r];
    pe_rand = 1;
    load(8, 1);
    run_check("latrand_drain");
    for (int r = 0; r < ROWS; r++) snap3[r*RW +: RW] = cap[r];
    chk("lat7_vs_lat1", 64'(snap2 != snap1), 0);
    chk("latrand_vs_lat1", 64'(snap3 != snap1), 0);

    // valid held for 9 beats: extra beat dropped
    rand_mat();
    load(9, 1);
    run_check("nine_beat_drain");

    // Reset while a rotation is outstanding
    pe_rand = 0;
    pe_lat = 7;
    rand_mat();
    load(8, 0);
    n = 0;
    while (!(cordic_req && cordic_mode == MODE_ROT) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_rot_wait", 64'(cordic_req && cordic_mode == MODE_ROT), 1);
    rst = 1'b1;
    #1;
    chk("midrst_req", cordic_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Fresh load after abort, random latency, spurious acks between ops
    pe_rand = 1;
    pe_spur = 1;
    rand_mat();
    load(8, 1);
    run_check("post_rst_drain");
    pe_spur = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
